fsk_bit_sync: RTL and testbench
===============================

// Module: fsk_bit_sync
// PURPOSE
//   Bit-timing recovery and data slicer fed by the FSK demodulator's filtered output (fir2_mix).
//   Applies a hysteresis slicer and tracks bit boundaries with a per-bit phase counter nudged
//   by data transitions (early/late). Emits one decided bit per bit period plus a lock flag.
//   Replaces the bare sign-bit slicer ahead of AD9764_INIT.
// PARAMETERS
//   DW        12   width of signed sample_in
//   SPB       16   samples per bit; even, >= 4
//   HYST      64   slicer hysteresis magnitude (LSBs of sample_in)
//   LOCK_BITS 8    consecutive good transitions required to assert locked
//   MAX_RUN   32   bit strobes without any transition before lock is dropped
// PORTS
//   clk           in   1    system clock; all logic on rising edge
//   rst           in   1    synchronous reset, active-high
//   sample_valid  in   1    one-cycle strobe per demodulated sample
//   sample_in     in   DW   signed two's-complement demodulator output
//   level         out  1    registered hysteresis-slicer state
//   bit_out       out  1    decided bit, valid with bit_valid
//   bit_valid     out  1    one-cycle strobe, once per SPB accepted samples
//   locked        out  1    timing-lock indicator
// BEHAVIOUR
//   Reset: level, bit_out, bit_valid, locked = 0; phase = 0; lock_cnt = 0; run_cnt = 0.
//   All state updates only on cycles with sample_valid = 1; otherwise hold (bit_valid = 0).
//   Slicer: new_level = 1 if sample_in > +HYST; 0 if sample_in < -HYST; else level.
//     Compare is signed, so exactly +/-HYST holds. level <= new_level (1-cycle latency).
//   trans = (new_level != level). e = phase (pre-update value, 0..SPB-1).
//   Phase update (one correction per transition, at most 1 sample):
//     no trans, or e == 0, or e == SPB/2   -> phase <= (phase+1) mod SPB
//     trans, 1 <= e <= SPB/2-1 (early)     -> phase <= phase (hold 1 sample)
//     trans, SPB/2+1 <= e <= SPB-1 (late)  -> phase <= (phase+2) mod SPB
//   Bit strobe: on accepted sample with pre-update phase == SPB/2:
//     bit_out <= new_level; bit_valid <= 1 next cycle. Hold/advance never duplicates or skips it.
//   Lock counter:
//     trans with e in {0, 1, SPB-1} -> lock_cnt <= min(lock_cnt+1, LOCK_BITS)
//     trans with any other e        -> lock_cnt <= 0, locked <= 0
//     locked <= 1 when lock_cnt reaches LOCK_BITS (next cycle)
//   Run counter: run_cnt cleared on any trans; else +1 per bit strobe, saturating at MAX_RUN.
//     Reaching MAX_RUN: locked <= 0, lock_cnt <= 0. Bits still emitted.
//   Same sample with trans and strobe: both take effect; trans clears run_cnt, strobe not counted.
//   bit_valid and bit_out are produced regardless of locked; consumer qualifies with locked.
//   rst mid-frame: all state returns to reset values on that edge; no partial strobe.
// TESTING
//   1 rst held 3 cycles amid random samples -> level/bit_out/bit_valid/locked = 0, no strobe.
//   2 Slicer: +50, +100, -30, -64, -100 -> level 0, 1, 1, 1, 0 (HYST=64, hold at exactly -64).
//   3 +/-500 alternating bits, edges at phase 0 -> bit_valid every 16 samples, bits 1,0,1,...
//     locked rises after 8th transition, phase never corrected.
//   4 Same pattern, edges at phase 4 -> 4 holds, edges land at e=0, locked after 8 good edges.
//   5 Edges at phase 12 -> advance 2 per edge until e in {0,1,15}; strobe count = bits sent exactly.
//   6 After lock, constant +500 for 32 bits -> locked drops at 32nd strobe, bit_out stays 1;
//     then rst pulse -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fsk_bit_sync.sv
// Bit-timing recovery and hysteresis data slicer for the FSK demodulator output.
// Tracks bit boundaries with a per-bit phase counter nudged early/late by data transitions.
module fsk_bit_sync #(
  parameter int DW        = 12,
  parameter int SPB       = 16,
  parameter int HYST      = 64,
  parameter int LOCK_BITS = 8,
  parameter int MAX_RUN   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] sample_in,
  output logic                 level,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 locked
);

  localparam int PW = $clog2(SPB);
  localparam int LW = $clog2(LOCK_BITS + 1);
  localparam int RW = $clog2(MAX_RUN + 1);

  localparam logic signed [DW-1:0] HYST_P = DW'(HYST);
  localparam logic signed [DW-1:0] HYST_N = -HYST_P;

  localparam logic [PW-1:0] PH_HALF = PW'(SPB / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(SPB - 1);
  localparam logic [PW-1:0] PH_WRAP = PW'(SPB - 2);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_BITS);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RUN);

  // Phase correction applied on an accepted sample.
  typedef enum logic [1:0] {
    CORR_STEP,  // normal advance by one
    CORR_HOLD,  // early edge: stay one sample
    CORR_SKIP   // late edge: advance by two
  } corr_e;

  logic          level_q,     level_d;
  logic [PW-1:0] phase_q,     phase_d;
  logic          bit_out_q,   bit_out_d;
  logic          bit_valid_q, bit_valid_d;
  logic [LW-1:0] lock_cnt_q,  lock_cnt_d;
  logic [RW-1:0] run_cnt_q,   run_cnt_d;
  logic          locked_q,    locked_d;

  logic  new_level;
  logic  trans;
  logic  strobe;
  logic  good_edge;
  corr_e corr;

  // Slicer and per-sample event decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    new_level = level_q;
    if (sample_in > HYST_P) begin
      new_level = 1'b1;
    end else if (sample_in < HYST_N) begin
      new_level = 1'b0;
    end

    trans     = sample_valid && (new_level != level_q);
    strobe    = sample_valid && (phase_q == PH_HALF);
    good_edge = (phase_q == '0) || (phase_q == PW'(1)) || (phase_q == PH_LAST);

    corr = CORR_STEP;
    if (trans && (phase_q != '0) && (phase_q != PH_HALF)) begin
      corr = (phase_q < PH_HALF) ? CORR_HOLD : CORR_SKIP;
    end
  end

  // Next-state logic for phase, bit output, lock and run counters.
  always_comb begin
    level_d     = level_q;
    phase_d     = phase_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    lock_cnt_d  = lock_cnt_q;
    run_cnt_d   = run_cnt_q;
    locked_d    = locked_q;

    if (sample_valid) begin
      level_d = new_level;

      unique case (corr)
        CORR_HOLD: phase_d = phase_q;
        CORR_SKIP: phase_d = (phase_q >= PH_WRAP) ? phase_q - PH_WRAP : phase_q + PW'(2);
        default:   phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      endcase

      if (strobe) begin
        bit_out_d   = new_level;
        bit_valid_d = 1'b1;
      end

      // A transition takes precedence over the strobe for the run counter.
      if (trans) begin
        run_cnt_d = '0;
        if (good_edge) begin
          if (lock_cnt_q < LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LW'(1);
          end
          if (lock_cnt_d == LOCK_MAX) begin
            locked_d = 1'b1;
          end
        end else begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end
      end else if (strobe && (run_cnt_q != RUN_MAX)) begin
        run_cnt_d = run_cnt_q + RW'(1);
        if (run_cnt_d == RUN_MAX) begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      level_q     <= 1'b0;
      phase_q     <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      lock_cnt_q  <= '0;
      run_cnt_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      level_q     <= level_d;
      phase_q     <= phase_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      lock_cnt_q  <= lock_cnt_d;
      run_cnt_q   <= run_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign level     = level_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_fsk_bit_sync.sv
// Self-checking bench for fsk_bit_sync: directed scenarios plus randomized traffic
// compared every cycle against a behavioural bit-sync model.
module tb_fsk_bit_sync;

  localparam int DW        = 12;
  localparam int SPB       = 16;
  localparam int HYST      = 64;
  localparam int LOCK_BITS = 8;
  localparam int MAX_RUN   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sample_valid;
  logic signed [DW-1:0] sample_in;
  logic                 level;
  logic                 bit_out;
  logic                 bit_valid;
  logic                 locked;

  int n_checks = 0;
  int n_errors = 0;
  int dut_strobes = 0;

  // Behavioural model state.
  int m_level, m_phase, m_bit, m_bv, m_lock, m_run, m_locked;

  fsk_bit_sync #(
    .DW(DW), .SPB(SPB), .HYST(HYST), .LOCK_BITS(LOCK_BITS), .MAX_RUN(MAX_RUN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .level        (level),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_level = 0; m_phase = 0; m_bit = 0; m_bv = 0;
    m_lock = 0; m_run = 0; m_locked = 0;
  endfunction

  // One accepted-or-idle clock edge of the bit synchroniser, written from its rules.
  function automatic void model_step(input int r, input int v, input int s);
    int nl, e, tr, st;
    if (r != 0) begin
      model_reset();
      return;
    end
    m_bv = 0;
    if (v == 0) return;
    nl = (s > HYST) ? 1 : (s < -HYST) ? 0 : m_level;
    tr = (nl != m_level);
    e  = m_phase;
    st = (e == SPB / 2);
    if (!tr || e == 0 || e == SPB / 2) m_phase = (m_phase + 1) % SPB;
    else if (e < SPB / 2)              m_phase = m_phase;
    else                               m_phase = (m_phase + 2) % SPB;
    if (st) begin
      m_bit = nl;
      m_bv  = 1;
    end
    if (tr) begin
      m_run = 0;
      if (e == 0 || e == 1 || e == SPB - 1) begin
        m_lock = (m_lock + 1 > LOCK_BITS) ? LOCK_BITS : m_lock + 1;
        if (m_lock == LOCK_BITS) m_locked = 1;
      end else begin
        m_lock   = 0;
        m_locked = 0;
      end
    end else if (st) begin
      m_run = (m_run + 1 > MAX_RUN) ? MAX_RUN : m_run + 1;
      if (m_run == MAX_RUN) begin
        m_lock   = 0;
        m_locked = 0;
      end
    end
    m_level = nl;
  endfunction

  // Apply one cycle of inputs (called at negedge), then compare all outputs on the next negedge.
  task automatic cyc(input logic r, input logic v, input int s);
    rst          = r;
    sample_valid = v;
    sample_in    = DW'(s);
    @(posedge clk);
    model_step(int'(r), int'(v), s);
    @(negedge clk);
    check("level", level, m_level);
    check("bit_valid", bit_valid, m_bv);
    check("bit_out", bit_out, m_bit);
    check("locked", locked, m_locked);
    if (bit_valid === 1'b1) dut_strobes++;
  endtask

  task automatic send_bit(input int b, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, (b != 0) ? 500 : -500);
  endtask

  task automatic idle_samples(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, int'($urandom_range(0, 4095)) - 2048);
  endtask

  function automatic int rand_sample(input int b);
    int amp;
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, 4095)) - 2048;
    amp = int'($urandom_range(HYST + 1, 900));
    return (b != 0) ? amp : -amp;
  endfunction

  initial begin
    int exp_lvl [5];
    int slc_in  [5];
    int nbits;

    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    model_reset();

    // Reset held three cycles amid random samples.
    do_reset(3);
    check("rst_level", level, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_locked", locked, 0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, int'($urandom_range(0, 4095)) - 2048);
    dut_strobes = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, int'($urandom_range(0, 4095)) - 2048);
      check("rst_hold_level", level, 0);
      check("rst_hold_bit_out", bit_out, 0);
      check("rst_hold_bit_valid", bit_valid, 0);
      check("rst_hold_locked", locked, 0);
    end
    check("rst_no_strobe", dut_strobes, 0);

    // Slicer hysteresis, including the exact -HYST hold.
    slc_in  = '{50, 100, -30, -64, -100};
    exp_lvl = '{0, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, slc_in[i]);
      check("slicer_level", level, exp_lvl[i]);
    end

    // Alternating bits with edges at phase 0.
    do_reset(1);
    dut_strobes = 0;
    for (int k = 0; k < 7; k++) send_bit((k % 2 == 0) ? 1 : 0, SPB);
    check("t3_unlocked_after_7", locked, 0);
    cyc(1'b0, 1'b1, -500);
    check("t3_locked_after_8", locked, 1);
    send_bit(0, SPB - 1);
    for (int k = 8; k < 16; k++) send_bit((k % 2 == 0) ? 1 : 0, SPB);
    check("t3_strobe_count", dut_strobes, 16);
    check("t3_locked", locked, 1);

    // Constant 1s after lock: lock drops exactly at the 32nd strobe.
    for (int i = 0; i < 31 * SPB + SPB / 2; i++) cyc(1'b0, 1'b1, 500);
    check("t6_locked_before_32", locked, 1);
    cyc(1'b0, 1'b1, 500);
    check("t6_strobe_32", bit_valid, 1);
    check("t6_unlocked_at_32", locked, 0);
    check("t6_bit_out", bit_out, 1);
    send_bit(1, SPB / 2 - 1);
    cyc(1'b1, 1'b1, 500);
    check("t6_rst_level", level, 0);
    check("t6_rst_bit_out", bit_out, 0);
    check("t6_rst_bit_valid", bit_valid, 0);
    check("t6_rst_locked", locked, 0);

    // Edges at phase 4: early holds pull them back to phase 0.
    do_reset(1);
    idle_samples(4);
    dut_strobes = 0;
    for (int k = 0; k < 16; k++) send_bit((k % 2 == 0) ? 1 : 0, SPB);
    check("t4_strobe_count", dut_strobes, 16);
    check("t4_locked", locked, 1);

    // Edges at phase 12: late advances until aligned.
    do_reset(1);
    idle_samples(12);
    dut_strobes = 0;
    for (int k = 0; k < 20; k++) send_bit((k % 2 == 0) ? 1 : 0, SPB);
    check("t5_strobe_count", dut_strobes, 20);
    check("t5_locked", locked, 1);

    // Randomized traffic: jittered bit lengths, noise, gaps in sample_valid, rare resets.
    do_reset(1);
    for (int b = 0; b < 300; b++) begin
      int bv;
      bv    = int'($urandom_range(0, 1));
      nbits = int'($urandom_range(SPB - 2, SPB + 2));
      for (int i = 0; i < nbits; i++) begin
        if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, int'($urandom_range(0, 4095)) - 2048);
        cyc($urandom_range(0, 999) == 0, 1'b1, rand_sample(bv));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
